// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, NZCV bit positions,
// FSM state encoding and a small opcode classification helper.
package alu_pipe_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  // Bit positions inside the {N,Z,C,V} status vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Only the adder-based ops produce meaningful C and V
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == ALU_ADD) || (cmd == ALU_ADC) ||
           (cmd == ALU_SUB) || (cmd == ALU_SBC);
  endfunction

endpackage

// File: rtl/alu_pipe_seq_mul.sv
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// A start pulse captures the operands; one multiplier bit is consumed per
// cycle for DATA_W cycles, after which done stays high and p stays stable
// until the next start.
module alu_seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops and an optional
// iterative multiply behind a valid/ready handshake, with a one-entry output
// register and an internal NZCV status register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised, holds its payload stable until that transfer, and
// ready may depend combinationally on the other side's valid/ready.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exec_cmd,
  input  logic              s_en,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        nzcv,
  output state_e            dbg_state
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic              mul_s_en_q, mul_s_en_d;

  logic              out_free;
  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;

  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              is_sub;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  // The output register can take a new result if it is empty or draining this edge
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (exec_cmd == ALU_MUL);

  // Single-cycle datapath: one DATA_W+1 bit adder shared by ADD/ADC/SUB/SBC
  always_comb begin
    add_b   = in2;
    add_cin = 1'b0;
    is_sub  = 1'b0;
    case (exec_cmd)
      ALU_ADC: add_cin = nzcv_q[FLAG_C];
      ALU_SUB: begin add_b = ~in2; add_cin = 1'b1;           is_sub = 1'b1; end
      ALU_SBC: begin add_b = ~in2; add_cin = nzcv_q[FLAG_C]; is_sub = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, in1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    alu_c = sum[DATA_W];
    if (is_sub) alu_v = (in1[MSB] != in2[MSB]) && (sum[MSB] != in1[MSB]);
    else        alu_v = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
    case (exec_cmd)
      ALU_MOV: alu_res = in2;
      ALU_MVN: alu_res = ~in2;
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: alu_res = sum[DATA_W-1:0];
      ALU_AND: alu_res = in1 & in2;
      ALU_ORR: alu_res = in1 | in2;
      ALU_EOR: alu_res = in1 ^ in2;
      default: alu_res = in1;
    endcase
  end

  // FSM next state, output-register load and flag update
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    nzcv_d      = nzcv_q;
    mul_s_en_d  = mul_s_en_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d    = ST_MUL;
            mul_start  = 1'b1;
            mul_s_en_d = s_en;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            if (s_en) begin
              nzcv_d[FLAG_N] = alu_res[MSB];
              nzcv_d[FLAG_Z] = (alu_res == '0);
              if (is_arith(exec_cmd)) begin
                nzcv_d[FLAG_C] = alu_c;
                nzcv_d[FLAG_V] = alu_v;
              end
            end
          end
        end
      end
      ST_MUL: begin
        // Hold the finished product here until the output register is free
        if (mul_done && out_free) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_p;
          if (mul_s_en_q) begin
            nzcv_d[FLAG_N] = mul_p[MSB];
            nzcv_d[FLAG_Z] = (mul_p == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output register and status register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nzcv_q      <= '0;
      mul_s_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      nzcv_q      <= nzcv_d;
      mul_s_en_q  <= mul_s_en_d;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (in1),
        .b     (in2),
        .done  (mul_done),
        .p     (mul_p)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_p    = '0;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign nzcv      = nzcv_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a MUL_EN=1 instance exercised through reset,
// flag, multiply and backpressure steps, plus a MUL_EN=0 instance for the
// unknown-opcode MUL case.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with multiplier ----------------
  logic         in_valid, in_ready, s_en, out_valid, out_ready;
  logic [3:0]   exec_cmd, nzcv;
  logic [W-1:0] in1, in2, result;
  state_e       dbg_state;

  alu_pipe #(.DATA_W(W), .MUL_EN(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exec_cmd  (exec_cmd),
    .s_en      (s_en),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .nzcv      (nzcv),
    .dbg_state (dbg_state)
  );

  // ---------------- DUT without multiplier ----------------
  logic         in_valid0, in_ready0, s_en0, out_valid0, out_ready0;
  logic [3:0]   exec_cmd0, nzcv0;
  logic [W-1:0] in10, in20, result0;
  state_e       dbg_state0;

  alu_pipe #(.DATA_W(W), .MUL_EN(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .exec_cmd  (exec_cmd0),
    .s_en      (s_en0),
    .in1       (in10),
    .in2       (in20),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .result    (result0),
    .nzcv      (nzcv0),
    .dbg_state (dbg_state0)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         sb_on = 1'b0;
  int           delivered = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present an op at a negedge, wait (bounded) for in_ready, return at the
  // negedge after the accepting edge with in_valid still high.
  task automatic issue(input logic [3:0] cmd, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    exec_cmd = cmd; s_en = s; in1 = a; in2 = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("issue_in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns the number of negedges waited
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] sb_exp;
  always @(negedge clk) begin
    #2;
    if (sb_on && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_extra_result: observed %0h expected none", result);
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check("sb_result", result, sb_exp);
        delivered++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int lat;
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; exec_cmd = 4'd0; s_en = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b1;
    in_valid0 = 1'b0; exec_cmd0 = 4'd0; s_en0 = 1'b0; in10 = '0; in20 = '0; out_ready0 = 1'b1;

    // Step 1: reset values, then a reset pulse in the middle of a MUL
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_in_ready0", in_ready0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_nzcv", nzcv, 4'b0000);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    issue(ALU_MUL, 1'b1, 32'd3, 32'd5);
    idle();
    repeat (4) @(negedge clk);
    check("mid_mul_state", dbg_state, ST_MUL);
    check("mid_mul_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst_high", in_ready, 0);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_nzcv", nzcv, 4'b0000);
    repeat (40) @(negedge clk);
    check("abort_no_late_result", out_valid, 0);

    // Step 2: SUBS 1-3
    issue(ALU_SUB, 1'b1, 32'd1, 32'd3);
    check("subs_result", result, 32'hFFFF_FFFE);
    check("subs_nzcv", nzcv, 4'b1000);
    check("subs_out_valid", out_valid, 1);
    idle();
    @(negedge clk);
    check("subs_drained", out_valid, 0);

    // Step 3: signed overflow, then ADC without flag update
    issue(ALU_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1);
    check("adds_ovf_result", result, 32'h8000_0000);
    check("adds_ovf_nzcv", nzcv, 4'b1001);
    issue(ALU_ADC, 1'b0, 32'd0, 32'd0);
    check("adc_nos_result", result, 32'd0);
    check("adc_nos_nzcv", nzcv, 4'b1001);
    idle();

    // Step 4: wrap-around sets C, back-to-back ADCS consumes it
    issue(ALU_ADD, 1'b1, 32'hFFFF_FFFF, 32'd1);
    check("adds_wrap_result", result, 32'd0);
    check("adds_wrap_nzcv", nzcv, 4'b0110);
    issue(ALU_ADC, 1'b1, 32'd5, 32'd5);
    check("adcs_result", result, 32'd11);
    check("adcs_nzcv", nzcv, 4'b0000);
    idle();

    // Step 5: set C and V, then MULS must update only N/Z and take 33 cycles
    issue(ALU_SUB, 1'b1, 32'h8000_0000, 32'd1);
    check("subs_cv_result", result, 32'h7FFF_FFFF);
    check("subs_cv_nzcv", nzcv, 4'b0011);
    issue(ALU_MUL, 1'b1, 32'h0001_0000, 32'h0001_0000);
    idle();
    check("mul_state", dbg_state, ST_MUL);
    check("mul_in_ready", in_ready, 0);
    wait_out(lat);
    check("mul_latency", lat, 33);
    check("muls_result", result, 32'd0);
    check("muls_nzcv", nzcv, 4'b0111);
    @(negedge clk);
    issue(ALU_MUL, 1'b0, 32'd6, 32'd7);
    idle();
    wait_out(lat);
    check("mul_latency2", lat, 33);
    check("mul_6x7_result", result, 32'd42);
    check("mul_6x7_nzcv", nzcv, 4'b0111);
    @(negedge clk);

    // MUL_EN=0 instance: MUL behaves as an unknown opcode
    check("nomul_in_ready", in_ready0, 1);
    exec_cmd0 = ALU_MUL; s_en0 = 1'b1; in10 = 32'd6; in20 = 32'd7; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    check("nomul_out_valid", out_valid0, 1);
    check("nomul_result", result0, 32'd6);
    check("nomul_nzcv", nzcv0, 4'b0000);

    // Step 6: backpressure with scoreboard tracking every delivered result
    @(negedge clk);
    check("bp_start_empty", out_valid, 0);
    sb_on = 1'b1;
    delivered = 0;
    out_ready = 1'b0;
    exp_q.push_back(32'd30);
    issue(ALU_ADD, 1'b0, 32'd10, 32'd20);
    exec_cmd = ALU_ADD; s_en = 1'b0; in1 = 32'd1; in2 = 32'd2;
    exp_q.push_back(32'd3);
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result_stable", result, 32'd30);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    check("bp_no_bubble", out_valid, 1);
    check("bp_b_result", result, 32'd3);
    exec_cmd = ALU_AND; in1 = 32'hF0; in2 = 32'h3C;
    exp_q.push_back(32'h30);
    @(negedge clk);
    exec_cmd = ALU_ORR; in1 = 32'h0F; in2 = 32'hF0;
    exp_q.push_back(32'hFF);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    check("bp_drained", out_valid, 0);
    check("sb_queue_empty", exp_q.size(), 0);
    check("sb_delivered", delivered, 4);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
